// File: rtl/psum_sram_acc_rw.sv
// psum_sram_acc_rw
// Simple-dual-port partial-sum buffer with an in-memory accumulate mode.
// Each write either overwrites or adds lane-wise to the stored word, under a
// per-lane mask. The write path is a 2-stage read-modify-write pipeline:
//   S1 (edge E)  : capture the request and fetch the old word (forwarded).
//   S2 (cycle)   : combine old word and data; commit at edge E+1.
// The read port has 1-cycle latency and bypasses the commit happening at the
// same edge, so a read sampled at E sees every write sampled at E-1 or earlier.
//
// Optional build macro: PSUM_SAT_EN -- accumulate saturates each lane instead
// of wrapping modulo 2^LANE_W. Overwrite behaviour is unaffected.
//
// Ports:
//   CLK        clock, rising edge
//   reset      synchronous active-high reset (array contents are kept)
//   wen        write request
//   acc        1 = accumulate (old + D), 0 = overwrite
//   w_A        write address
//   lane_mask  per-lane write enable
//   D          write data, lane i = D[i*LANE_W +: LANE_W]
//   ren        read request
//   r_A        read address
//   Q          registered read data (0 for out-of-range addresses)
//   q_valid    high for the cycle after an accepted read
module psum_sram_acc_rw #(
   parameter int LANES  = 8,
   parameter int LANE_W = 16,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    wen,
   input  logic                    acc,
   input  logic [AW-1:0]           w_A,
   input  logic [LANES-1:0]        lane_mask,
   input  logic [LANES*LANE_W-1:0] D,
   input  logic                    ren,
   input  logic [AW-1:0]           r_A,
   output logic [LANES*LANE_W-1:0] Q,
   output logic                    q_valid
);

   localparam int W = LANES * LANE_W;

   logic [W-1:0] mem [DEPTH];

   // S1 registers
   logic             vld_p1;
   logic             acc_p1;
   logic [AW-1:0]    addr_p1;
   logic [LANES-1:0] mask_p1;
   logic [W-1:0]     data_p1;
   logic [W-1:0]     old_p1;

   // S2 result, committed at the next edge when vld_p1 is set
   logic [W-1:0]     new_p2;

   // Forwarded fetches for the write pipeline and the read port
   logic [W-1:0]     wr_old;
   logic [W-1:0]     rd_word;

   function automatic logic in_range(input logic [AW-1:0] a);
      return (32'(a) < DEPTH);
   endfunction

   function automatic logic [LANE_W-1:0] lane_add(input logic signed [LANE_W-1:0] a,
                                                  input logic signed [LANE_W-1:0] b);
`ifdef PSUM_SAT_EN
      logic signed [LANE_W:0] s;
      s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
      // Overflow when the extra sign bit disagrees with the result sign bit.
      if (s[LANE_W] != s[LANE_W-1])
         return s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
      return s[LANE_W-1:0];
`else
      return a + b;
`endif
   endfunction

   // Fetches see the commit happening at the same edge, so back-to-back
   // accumulates to one address and read-after-commit both use fresh data.
   // A valid S1 entry is always in range, so an address match implies in range.
   always_comb begin
      wr_old = '0;
      if (vld_p1 && addr_p1 == w_A)
         wr_old = new_p2;
      else if (in_range(w_A))
         wr_old = mem[w_A];
   end

   always_comb begin
      rd_word = '0;
      if (vld_p1 && addr_p1 == r_A)
         rd_word = new_p2;
      else if (in_range(r_A))
         rd_word = mem[r_A];
   end

   // ---- S1: capture request and old word ----
   always_ff @(posedge CLK) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         acc_p1  <= 1'b0;
         addr_p1 <= '0;
         mask_p1 <= '0;
         data_p1 <= '0;
         old_p1  <= '0;
      end else begin
         // Out-of-range writes never become valid, so they are dropped.
         vld_p1 <= wen && in_range(w_A);
         if (wen) begin
            acc_p1  <= acc;
            addr_p1 <= w_A;
            mask_p1 <= lane_mask;
            data_p1 <= D;
            old_p1  <= wr_old;
         end
      end
   end

   // ---- S2: per-lane merge ----
   always_comb begin
      new_p2 = old_p1;
      for (int i = 0; i < LANES; i++) begin
         if (mask_p1[i]) begin
            if (acc_p1)
               new_p2[i*LANE_W +: LANE_W] = lane_add(old_p1[i*LANE_W +: LANE_W],
                                                     data_p1[i*LANE_W +: LANE_W]);
            else
               new_p2[i*LANE_W +: LANE_W] = data_p1[i*LANE_W +: LANE_W];
         end
      end
   end

   // ---- Commit: array write (contents survive reset, pending commit does not) ----
   always_ff @(posedge CLK) begin
      if (!reset && vld_p1)
         mem[addr_p1] <= new_p2;
   end

   // ---- Read port ----
   always_ff @(posedge CLK) begin
      if (reset) begin
         Q       <= '0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= ren;
         if (ren)
            Q <= rd_word;
      end
   end

endmodule

// File: tb/tb_psum_sram_acc_rw.sv
// tb_psum_sram_acc_rw
// Bench for psum_sram_acc_rw (default parameters). A behavioural model keeps
// the buffer as an array of words: a write takes effect one edge after it is
// sampled unless that edge is a reset, and a read returns the array as it
// stands after that pending write is applied. Directed scenarios are followed
// by randomized traffic concentrated on a few addresses to stress hazards.
module tb_psum_sram_acc_rw;

   logic         CLK = 1'b0;
   logic         reset;
   logic         wen;
   logic         acc;
   logic [3:0]   w_A;
   logic [7:0]   lane_mask;
   logic [127:0] D;
   logic         ren;
   logic [3:0]   r_A;
   logic [127:0] Q;
   logic         q_valid;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [127:0] mdl [16];
   logic         pend_v;
   logic         pend_acc;
   logic [3:0]   pend_a;
   logic [7:0]   pend_m;
   logic [127:0] pend_d;
   logic [127:0] exp_q;
   logic         exp_qv;

   psum_sram_acc_rw #(.LANES(8), .LANE_W(16), .DEPTH(16), .AW(4)) dut (
      .CLK(CLK), .reset(reset), .wen(wen), .acc(acc), .w_A(w_A),
      .lane_mask(lane_mask), .D(D), .ren(ren), .r_A(r_A), .Q(Q), .q_valid(q_valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SAT_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`endif
      return s[15:0];
   endfunction

   function automatic logic [127:0] splat(input logic [15:0] v);
      return {8{v}};
   endfunction

   task automatic model_apply();
      logic [127:0] w;
      w = mdl[pend_a];
      for (int i = 0; i < 8; i++)
         if (pend_m[i])
            w[i*16 +: 16] = pend_acc ? m_add(w[i*16 +: 16], pend_d[i*16 +: 16])
                                     : pend_d[i*16 +: 16];
      mdl[pend_a] = w;
   endtask

   // One clock: drive inputs, advance the model across the edge, check outputs.
   task automatic step(input logic w, input logic a, input logic [3:0] wa,
                       input logic [7:0] m, input logic [127:0] d,
                       input logic r, input logic [3:0] ra, input logic rst);
      reset = rst; wen = w; acc = a; w_A = wa; lane_mask = m; D = d;
      ren = r; r_A = ra;
      @(posedge CLK);
      if (rst) begin
         pend_v = 1'b0;
         exp_q  = '0;
         exp_qv = 1'b0;
      end else begin
         if (pend_v) model_apply();
         exp_qv = r;
         if (r) exp_q = mdl[ra];
         pend_v = w; pend_acc = a; pend_a = wa; pend_m = m; pend_d = d;
      end
      #1;
      chk("q_valid", 128'(q_valid), 128'(exp_qv));
      chk("Q", Q, exp_q);
   endtask

   task automatic wr(input logic [3:0] a, input logic ac, input logic [7:0] m, input logic [127:0] d);
      step(1'b1, ac, a, m, d, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a);
      step(1'b0, 1'b0, 4'd0, 8'h00, '0, 1'b1, a, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 8'h00, '0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      logic [127:0] v;
      logic [15:0]  ovf_a, ovf_b;
      pend_v = 1'b0; pend_acc = 1'b0; pend_a = '0; pend_m = '0; pend_d = '0;
      exp_q = '0; exp_qv = 1'b0;
      for (int i = 0; i < 16; i++) mdl[i] = '0;

      // Reset state
      step(1'b0, 1'b0, 4'd0, 8'h00, '0, 1'b1, 4'd0, 1'b1);
      step(1'b0, 1'b0, 4'd0, 8'h00, '0, 1'b0, 4'd0, 1'b1);
      chk("reset_Q", Q, '0);
      chk("reset_q_valid", 128'(q_valid), 128'(0));

      // Give every word a known value
      for (int i = 0; i < 16; i++) wr(4'(i), 1'b0, 8'hFF, '0);
      idle();

      // Overwrite then read
      for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(i + 1);
      wr(4'd3, 1'b0, 8'hFF, v);
      idle();
      rd(4'd3);
      chk("ovw_Q", Q, v);
      chk("ovw_qv", 128'(q_valid), 128'(1));
      idle();
      chk("ovw_qv_pulse", 128'(q_valid), 128'(0));
      chk("ovw_Q_hold", Q, v);

      // Back-to-back accumulate
      wr(4'd5, 1'b0, 8'hFF, splat(16'd10));
      for (int i = 0; i < 4; i++) wr(4'd5, 1'b1, 8'hFF, splat(16'd1));
      rd(4'd5);
      chk("acc_b2b", Q, splat(16'd14));

      // Lane mask
      wr(4'd2, 1'b0, 8'hFF, splat(16'd100));
      wr(4'd2, 1'b1, 8'h0F, splat(16'd5));
      rd(4'd2);
      chk("lane_mask", Q, {{4{16'd100}}, {4{16'd105}}});

      // Read-before-write, then commit bypass
      wr(4'd7, 1'b0, 8'hFF, '0);
      idle();
      step(1'b1, 1'b0, 4'd7, 8'hFF, splat(16'h1234), 1'b1, 4'd7, 1'b0);
      chk("rbw", Q, '0);
      rd(4'd7);
      chk("bypass", Q, splat(16'h1234));

      // Overflow
`ifdef PSUM_SAT_EN
      ovf_a = 16'h7FFF; ovf_b = 16'h8000;
`else
      ovf_a = 16'h8000; ovf_b = 16'h7FFF;
`endif
      wr(4'd1, 1'b0, 8'hFF, splat(16'h7FFF));
      wr(4'd1, 1'b1, 8'hFF, splat(16'h0001));
      rd(4'd1);
      chk("ovf_pos", Q, splat(ovf_a));
      wr(4'd1, 1'b0, 8'hFF, splat(16'h8000));
      wr(4'd1, 1'b1, 8'hFF, splat(16'hFFFF));
      rd(4'd1);
      chk("ovf_neg", Q, splat(ovf_b));

      // Reset mid-operation: pending commit and reset-edge requests are dropped
      wr(4'd9, 1'b0, 8'hFF, splat(16'h0055));
      idle();
      wr(4'd9, 1'b0, 8'hFF, splat(16'hAAAA));
      step(1'b1, 1'b0, 4'd9, 8'hFF, splat(16'h3333), 1'b1, 4'd9, 1'b1);
      chk("rst_Q", Q, '0);
      chk("rst_qv", 128'(q_valid), 128'(0));
      rd(4'd9);
      chk("rst_keep", Q, splat(16'h0055));

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [3:0] wa, ra;
         wa = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
         v  = {$urandom, $urandom, $urandom, $urandom};
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), wa,
              8'($urandom), v, 1'($urandom_range(0, 1)), ra,
              1'($urandom_range(0, 59) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/psum_sram_acc_rw.md
# psum_sram_acc_rw

Parametrised simple-dual-port partial-sum SRAM with an in-memory accumulate mode, for the output/psum buffer behind the systolic array. One write port and one read port operate every cycle. Writes either overwrite or lane-wise add the incoming vector to the stored word, under a per-lane mask, through a 2-stage read-modify-write pipeline with full hazard forwarding. The read port has 1-cycle latency and sees every write issued in earlier cycles.

## Interface
- `LANES`, 8, number of psum lanes per word
- `LANE_W`, 16, bits per lane, two's complement
- `DEPTH`, 16, number of words
- `AW`, 4, address width; `2**AW >= DEPTH`
- `CLK`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `wen`  in  1  write request, sampled at the rising edge
- `acc`  in  1  1 = accumulate (`old + D`), 0 = overwrite; qualified by `wen`
- `w_A`  in  AW  write address
- `lane_mask`  in  LANES  per-lane write enable; a 0 lane keeps its old value
- `D`  in  LANES*LANE_W  write data; lane i is `D[i*LANE_W +: LANE_W]`
- `ren`  in  1  read request
- `r_A`  in  AW  read address
- `Q`  out  LANES*LANE_W  registered read data
- `q_valid`  out  1  high for exactly the cycle after an accepted `ren`

## Operation
- **Array:** `DEPTH` words of `LANES*LANE_W` bits. Contents are undefined after power-up and are not cleared by `reset`.
- **Write stage 1 (S1):** at edge E with `wen=1`, register `acc`, `w_A`, `lane_mask`, `D` and set `s1_v`.
- **Write stage 2 (S2):** in the cycle after E, fetch `old = array[s1_addr]`, forwarded as below.
  - Per lane: if `lane_mask[i]=0`, `new_i = old_i`.
  - Else if `acc=1`, `new_i = old_i + D_i`.
  - Else `new_i = D_i`.
  - `new` is committed to the array at edge E+1.
- **Forwarding into S2:** if a commit to the same address happens at the edge that launches the S2 computation, `old` is that commit's `new` value, not the stale array word. Consecutive accumulates to one address therefore sum correctly at full rate.
- **Arithmetic:** lane-wise signed add, result `LANE_W` bits. Wrap modulo `2^LANE_W` unless `PSUM_SAT_EN` is defined. No carries cross lanes.
- **Read:** at edge E with `ren=1`, `Q` loads `array[r_A]`. If S2 commits to `r_A` at the same edge E, `Q` loads the committed `new` value (bypass).
  - Writes sampled at E itself are not visible to a read sampled at E (read-before-write).
  - `Q` holds its value until the next accepted `ren`.
- **Out-of-range addresses** (`>= DEPTH`): writes are dropped; reads return 0.
- **Reset:** at an edge with `reset=1`:
  - `s1_v` clears; a pending S2 commit is discarded (no array write).
  - `wen` and `ren` sampled at that edge are ignored.
  - `Q`, `q_valid` and all pipeline registers go to 0.

## Timing
- Write commit latency: 2 edges (sample at E, array updated at E+1). Throughput: 1 write per cycle.
- Read latency: 1 edge. `Q` and `q_valid` are valid after edge E. Throughput: 1 read per cycle.
- Read-after-write visibility: a read sampled at E returns all writes sampled at edges ≤ E-1.
- Simultaneous `wen` and `ren` to the same address: the read returns the pre-write value.
- Reset values: `Q`=0, `q_valid`=0.
- No stalls and no backpressure; inputs are accepted every cycle.

## Configuration
- `PSUM_SAT_EN` defined:
  - Accumulate saturates each lane to [-2^(LANE_W-1), 2^(LANE_W-1)-1].
  - Positive overflow clamps to max; negative overflow clamps to min.
- `PSUM_SAT_EN` undefined: two's-complement wrap. Overwrite mode is identical either way.

## Test plan
- **Overwrite then read:** write addr 3 = lanes {1..8}, mask 0xFF, `acc=0`; `ren` addr 3 two cycles later → `Q` lanes {1..8}, `q_valid` pulses once.
- **Back-to-back accumulate:** overwrite addr 5 = all lanes 10; then 4 consecutive `acc=1` writes of all lanes 1 to addr 5 → read gives 14 in every lane (exercises S2 forwarding).
- **Lane mask:** addr 2 = all 100; `acc=1`, `D` = all 5, mask 0x0F → lanes 0-3 = 105, lanes 4-7 = 100.
- **Bypass and read-before-write:**
  - Write addr 7 = 0x1234 all lanes at E; `ren` addr 7 at E+1 → `Q` = 0x1234 (commit bypass).
  - `ren` addr 7 at E with old value 0 → `Q` = 0.
- **Overflow:** lane = 0x7FFF, accumulate +1 → 0x8000 without `PSUM_SAT_EN`, 0x7FFF with it; 0x8000 + (-1) → 0x7FFF / 0x8000 respectively.
- **Reset mid-operation:** assert `reset` the cycle after a write to addr 9 (old value 0x0055) is sampled → addr 9 still reads 0x0055; `Q`=0 and `q_valid`=0 on the reset edge.
